// File: rtl/multiboot_pkg.sv
// Shared definitions for the multiboot trigger: FSM state encoding, request
// source codes, boot addresses and a pulse-width helper.
package multiboot_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_QUIESCE = 3'd2,
        S_PULSE   = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    localparam logic [1:0]  SRC_NONE   = 2'b00;
    localparam logic [1:0]  SRC_SW     = 2'b01;
    localparam logic [1:0]  SRC_MASTER = 2'b10;

    localparam logic [23:0] DEFAULT_ADDR   = 24'h058000;
    localparam logic [23:0] MB_GOLDEN_ADDR = 24'h000000;

    // Last pulse-counter value; out-of-range widths are clamped into 2..15.
    function automatic logic [3:0] pulse_last(input int unsigned cyc);
        logic [3:0] last;
        if (cyc < 32'd2) begin
            last = 4'd1;
        end else if (cyc > 32'd15) begin
            last = 4'd14;
        end else begin
            last = 4'(cyc - 32'd1);
        end
        return last;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear/enable; flags when the
// programmed terminal value is reached and holds there.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         at_term
);

    logic [W-1:0] count_r;

    // Count register: clear has priority, never advances past term.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != term)) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign at_term = (count_r == term);

endmodule

// File: rtl/multiboot_trigger.sv
// Reboot trigger: software request or held master combo -> quiesce the
// system -> fixed-width boot_core pulse -> lock until reset.
module multiboot_trigger
    import multiboot_pkg::*;
#(
    parameter logic [23:0] HOLD_CYC    = 24'd8_400_000,
    parameter logic [15:0] QUIESCE_TO  = 16'd1024,
    parameter int unsigned PULSE_CYC   = 4,
    parameter logic [23:0] GOLDEN_ADDR = MB_GOLDEN_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_req,
    input  logic [23:0] sw_addr,
    input  logic        key_master,
    input  logic        quiesce_ack,
    output logic        quiesce_req,
    output logic [23:0] spi_addr,
    output logic        boot_core,
    output logic        busy,
    output logic [1:0]  src
);

    localparam logic [23:0] HOLD_TERM  = HOLD_CYC - 24'd1;
    localparam logic [15:0] TO_TERM    = QUIESCE_TO - 16'd1;
    localparam logic [3:0]  PULSE_LAST = pulse_last(PULSE_CYC);

    state_t     state_r;
    logic [3:0] pulse_cnt_r;
    logic       hold_clr_s;
    logic       to_clr_s;
    logic       hold_term_s;
    logic       to_term_s;

    // Counter controls: each counter runs only in its own state, and the
    // hold counter restarts whenever the combo is released.
    always_comb begin
        hold_clr_s = 1'b1;
        to_clr_s   = 1'b1;
        if ((state_r == S_HOLD) && key_master) begin
            hold_clr_s = 1'b0;
        end else begin
            hold_clr_s = 1'b1;
        end
        if (state_r == S_QUIESCE) begin
            to_clr_s = 1'b0;
        end else begin
            to_clr_s = 1'b1;
        end
    end

    sat_counter #(.W(24)) u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (hold_clr_s),
        .en      (1'b1),
        .term    (HOLD_TERM),
        .at_term (hold_term_s)
    );

    sat_counter #(.W(16)) u_to_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr_s),
        .en      (1'b1),
        .term    (TO_TERM),
        .at_term (to_term_s)
    );

    // Trigger FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            pulse_cnt_r <= 4'd0;
            quiesce_req <= 1'b0;
            boot_core   <= 1'b0;
            busy        <= 1'b0;
            src         <= SRC_NONE;
            spi_addr    <= DEFAULT_ADDR;
        end else begin
            case (state_r)
                S_IDLE: begin
                    // Master combo wins over a simultaneous software request.
                    if (key_master) begin
                        state_r <= S_HOLD;
                        busy    <= 1'b1;
                    end else if (sw_req) begin
                        state_r     <= S_QUIESCE;
                        spi_addr    <= sw_addr;
                        src         <= SRC_SW;
                        quiesce_req <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!key_master) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (hold_term_s) begin
                        state_r     <= S_QUIESCE;
                        spi_addr    <= GOLDEN_ADDR;
                        src         <= SRC_MASTER;
                        quiesce_req <= 1'b1;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                S_QUIESCE: begin
                    if (quiesce_ack || to_term_s) begin
                        state_r     <= S_PULSE;
                        boot_core   <= 1'b1;
                        pulse_cnt_r <= 4'd0;
                    end else begin
                        state_r <= S_QUIESCE;
                    end
                end
                S_PULSE: begin
                    if (pulse_cnt_r == PULSE_LAST) begin
                        state_r   <= S_LOCKED;
                        boot_core <= 1'b0;
                    end else begin
                        pulse_cnt_r <= pulse_cnt_r + 4'd1;
                    end
                end
                S_LOCKED: begin
                    state_r <= S_LOCKED;
                end
                default: begin
                    state_r     <= S_IDLE;
                    pulse_cnt_r <= 4'd0;
                    quiesce_req <= 1'b0;
                    boot_core   <= 1'b0;
                    busy        <= 1'b0;
                    src         <= SRC_NONE;
                    spi_addr    <= DEFAULT_ADDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiboot_trigger.sv
// Directed self-checking bench for multiboot_trigger with shortened
// hold/timeout parameters.
module tb_multiboot_trigger;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_req;
    logic [23:0] sw_addr;
    logic        key_master;
    logic        quiesce_ack;
    logic        quiesce_req;
    logic [23:0] spi_addr;
    logic        boot_core;
    logic        busy;
    logic [1:0]  src;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multiboot_trigger #(
        .HOLD_CYC    (24'd100),
        .QUIESCE_TO  (16'd16),
        .PULSE_CYC   (4),
        .GOLDEN_ADDR (24'h000000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_req      (sw_req),
        .sw_addr     (sw_addr),
        .key_master  (key_master),
        .quiesce_ack (quiesce_ack),
        .quiesce_req (quiesce_req),
        .spi_addr    (spi_addr),
        .boot_core   (boot_core),
        .busy        (busy),
        .src         (src)
    );

    // One active edge, then settle 1 time unit before looking or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sw_req = 1'b0;
        key_master = 1'b0;
        quiesce_ack = 1'b0;
        sw_addr = 24'h000000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_qreq", {31'd0, quiesce_req}, 32'd0);
        chk("rst_boot", {31'd0, boot_core}, 32'd0);
        chk("rst_src", {30'd0, src}, 32'd0);
        chk("rst_addr", {8'd0, spi_addr}, 32'h058000);

        // Software path, ack five cycles after the request.
        sw_req = 1'b1; sw_addr = 24'h0A0000;
        tick();
        sw_req = 1'b0;
        chk("sw_qreq", {31'd0, quiesce_req}, 32'd1);
        chk("sw_busy", {31'd0, busy}, 32'd1);
        chk("sw_addr", {8'd0, spi_addr}, 32'h0A0000);
        chk("sw_src", {30'd0, src}, 32'd1);
        sw_req = 1'b1; sw_addr = 24'h123456;
        tick();
        sw_req = 1'b0;
        tick();
        tick();
        tick();
        chk("q_addr_hold", {8'd0, spi_addr}, 32'h0A0000);
        chk("q_no_boot", {31'd0, boot_core}, 32'd0);
        quiesce_ack = 1'b1;
        tick();
        quiesce_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sw_pulse%0d", i), {31'd0, boot_core}, 32'd1);
            tick();
        end
        chk("sw_pulse_end", {31'd0, boot_core}, 32'd0);
        chk("lock_qreq", {31'd0, quiesce_req}, 32'd1);
        chk("lock_busy", {31'd0, busy}, 32'd1);
        sw_req = 1'b1; sw_addr = 24'h654321;
        tick();
        sw_req = 1'b0;
        tick();
        chk("lock_boot", {31'd0, boot_core}, 32'd0);
        chk("lock_addr", {8'd0, spi_addr}, 32'h0A0000);
        chk("lock_src", {30'd0, src}, 32'd1);

        // Combo held for HOLD_CYC edges only: must not fire.
        do_reset();
        key_master = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        chk("hold_short_busy", {31'd0, busy}, 32'd1);
        chk("hold_short_qreq", {31'd0, quiesce_req}, 32'd0);
        key_master = 1'b0;
        tick();
        chk("hold_rel_busy", {31'd0, busy}, 32'd0);
        chk("hold_rel_addr", {8'd0, spi_addr}, 32'h058000);
        chk("hold_rel_src", {30'd0, src}, 32'd0);
        // Held through edge K+HOLD_CYC: fires exactly on that edge.
        key_master = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        chk("hold_pre_qreq", {31'd0, quiesce_req}, 32'd0);
        tick();
        key_master = 1'b0;
        chk("hold_fire_qreq", {31'd0, quiesce_req}, 32'd1);
        chk("hold_fire_addr", {8'd0, spi_addr}, 32'h000000);
        chk("hold_fire_src", {30'd0, src}, 32'd2);

        // Simultaneous request: combo wins, software address dropped.
        do_reset();
        sw_req = 1'b1; key_master = 1'b1; sw_addr = 24'h0ABCDE;
        tick();
        sw_req = 1'b0;
        chk("both_busy", {31'd0, busy}, 32'd1);
        chk("both_qreq", {31'd0, quiesce_req}, 32'd0);
        chk("both_addr", {8'd0, spi_addr}, 32'h058000);
        chk("both_src", {30'd0, src}, 32'd0);
        key_master = 1'b0;
        tick();
        chk("both_idle", {31'd0, busy}, 32'd0);

        // Timeout path: no ack, pulse after exactly 16 QUIESCE cycles.
        do_reset();
        sw_req = 1'b1; sw_addr = 24'h0C0000;
        tick();
        sw_req = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("to_pre_boot", {31'd0, boot_core}, 32'd0);
        tick();
        chk("to_boot", {31'd0, boot_core}, 32'd1);
        chk("to_addr", {8'd0, spi_addr}, 32'h0C0000);

        // Reset during the second pulse cycle.
        tick();
        chk("p2_boot", {31'd0, boot_core}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("prst_boot", {31'd0, boot_core}, 32'd0);
        chk("prst_busy", {31'd0, busy}, 32'd0);
        chk("prst_addr", {8'd0, spi_addr}, 32'h058000);
        sw_req = 1'b1; sw_addr = 24'h0E0000;
        tick();
        sw_req = 1'b0;
        chk("fresh_addr", {8'd0, spi_addr}, 32'h0E0000);
        chk("fresh_src", {30'd0, src}, 32'd1);
        quiesce_ack = 1'b1;
        tick();
        quiesce_ack = 1'b0;
        chk("fresh_boot", {31'd0, boot_core}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
